// File: rtl/uart_rx_fifo_if.sv
// Bundle of the uart_rx_fifo serial input, pop handshake and status signals.
// master drives the line and pops; slave is the receiver/FIFO side.
`timescale 1ns/1ps
interface uart_rx_fifo_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic                  rxd;
    logic                  rd_en;
    logic                  clr_err;
    logic [7:0]            rd_data;
    logic                  empty;
    logic                  full;
    logic [DEPTH_LOG2:0]   count;
    logic                  frame_err;
    logic                  overrun;
    logic                  parity_err;

    modport master (
        output rxd, rd_en, clr_err,
        input  rd_data, empty, full, count, frame_err, overrun, parity_err
    );

    modport slave (
        input  rxd, rd_en, clr_err,
        output rd_data, empty, full, count, frame_err, overrun, parity_err
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) feeding a
// first-word fall-through FIFO with sticky frame/overrun/parity error flags.
`timescale 1ns/1ps
module uart_rx_fifo #(
    parameter int CLK_FREQ   = 10000000,
    parameter int BAUD       = 115200,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                clk_10M,
    input  logic                reset_of_clk10M,
    input  logic                rxd,
    input  logic                rd_en,
    input  logic                clr_err,
    output logic [7:0]          rd_data,
    output logic                empty,
    output logic                full,
    output logic [DEPTH_LOG2:0] count,
    output logic                frame_err,
    output logic                overrun,
    output logic                parity_err
);
    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned DEPTH        = 1 << DEPTH_LOG2;
    localparam int unsigned CW           = DEPTH_LOG2 + 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } rx_state_t;

    logic                  rx_meta_q;
    logic                  rx_sync_q;
    logic                  rx_prev_q;
    rx_state_t             state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [2:0]            bit_idx_q;
    logic [7:0]            shift_q;
    logic                  frame_err_q;
    logic                  overrun_q;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [CW-1:0]         count_q;

    logic bit_end;
    logic stop_sample;
    logic push_req;
    logic frame_bad;
    logic fifo_empty;
    logic fifo_full;
    logic do_pop;
    logic do_push;
    logic drop;

    always_ff @(posedge clk_10M or posedge reset_of_clk10M) begin
        if (reset_of_clk10M) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rxd;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    assign bit_end     = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    assign stop_sample = (state_q == STOP) && bit_end;
    assign frame_bad   = stop_sample && !rx_sync_q;

`ifdef UART_RX_PARITY_EN
    logic par_bad_q;
    logic parity_err_q;
    logic par_mismatch;

    // Even parity: data bits plus parity bit must XOR to zero.
    assign par_mismatch = (state_q == PARITY) && bit_end && ((^shift_q) ^ rx_sync_q);
    assign push_req     = stop_sample && rx_sync_q && !par_bad_q;

    always_ff @(posedge clk_10M or posedge reset_of_clk10M) begin
        if (reset_of_clk10M) begin
            parity_err_q <= 1'b0;
        end else if (par_mismatch) begin
            parity_err_q <= 1'b1;
        end else if (clr_err) begin
            parity_err_q <= 1'b0;
        end
    end

    assign parity_err = parity_err_q;
`else
    assign push_req   = stop_sample && rx_sync_q;
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk_10M or posedge reset_of_clk10M) begin
        if (reset_of_clk10M) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (rx_prev_q && !rx_sync_q) begin
                        state_q <= START;
                    end
                end
                START: begin
                    // Re-check the start bit at its midpoint to reject glitches.
                    if (cnt_q == CNT_W'(HALF_BIT)) begin
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        state_q   <= rx_sync_q ? IDLE : DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_sync_q, shift_q[7:1]};
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        cnt_q     <= '0;
                        par_bad_q <= (^shift_q) ^ rx_sync_q;
                        state_q   <= STOP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(DEPTH));
    assign do_pop     = rd_en && !fifo_empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign do_push    = push_req && (!fifo_full || do_pop);
    assign drop       = push_req && fifo_full && !do_pop;

    always_ff @(posedge clk_10M) begin
        if (do_push) begin
            mem[wr_ptr_q] <= shift_q;
        end
    end

    always_ff @(posedge clk_10M or posedge reset_of_clk10M) begin
        if (reset_of_clk10M) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_10M or posedge reset_of_clk10M) begin
        if (reset_of_clk10M) begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (frame_bad) begin
                frame_err_q <= 1'b1;
            end else if (clr_err) begin
                frame_err_q <= 1'b0;
            end
            if (drop) begin
                overrun_q <= 1'b1;
            end else if (clr_err) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign rd_data   = fifo_empty ? 8'h00 : mem[rd_ptr_q];
    assign empty     = fifo_empty;
    assign full      = fifo_full;
    assign count     = count_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: stimulus queues expected bytes, a monitor
// checks every pop; status flags are checked directly after each scenario.
`timescale 1ns/1ps
module tb_uart_rx_fifo;
    localparam int DL       = 4;
    localparam int BIT_CLKS = 10000000 / 115200;

    logic clk_10M = 1'b0;
    logic reset_of_clk10M = 1'b1;
    always #50 clk_10M = ~clk_10M;

    uart_rx_fifo_if #(.DEPTH_LOG2(DL)) bus ();

    uart_rx_fifo #(
        .CLK_FREQ   (10000000),
        .BAUD       (115200),
        .DEPTH_LOG2 (DL)
    ) dut (
        .clk_10M         (clk_10M),
        .reset_of_clk10M (reset_of_clk10M),
        .rxd             (bus.rxd),
        .rd_en           (bus.rd_en),
        .clr_err         (bus.clr_err),
        .rd_data         (bus.rd_data),
        .empty           (bus.empty),
        .full            (bus.full),
        .count           (bus.count),
        .frame_err       (bus.frame_err),
        .overrun         (bus.overrun),
        .parity_err      (bus.parity_err)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted pop is compared against the scoreboard head.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk_10M);
            if (!reset_of_clk10M && bus.rd_en && !bus.empty) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_unexpected: got 0x%0h expected no data", bus.rd_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("pop_data", 32'(bus.rd_data), 32'(e));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_10M);
        #1;
    endtask

    task automatic send_bits(input logic [10:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            bus.rxd = bits[i];
            tick(BIT_CLKS);
        end
        bus.rxd = 1'b1;
        tick(8);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b);
`ifdef UART_RX_PARITY_EN
        send_bits({stop_b, ^d, d, 1'b0}, 11);
`else
        send_bits({1'b0, stop_b, d, 1'b0}, 10);
`endif
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_frame_par(input logic [7:0] d, input logic par_b);
        send_bits({1'b1, par_b, d, 1'b0}, 11);
    endtask
`endif

    task automatic pop();
        @(posedge clk_10M);
        #1 bus.rd_en = 1'b1;
        @(posedge clk_10M);
        #1 bus.rd_en = 1'b0;
        @(negedge clk_10M);
    endtask

    task automatic pulse_clr();
        @(posedge clk_10M);
        #1 bus.clr_err = 1'b1;
        @(posedge clk_10M);
        #1 bus.clr_err = 1'b0;
        @(negedge clk_10M);
    endtask

    initial begin
        logic [7:0] partial;
        bus.rxd     = 1'b1;
        bus.rd_en   = 1'b0;
        bus.clr_err = 1'b0;
        repeat (3) @(posedge clk_10M);
        @(negedge clk_10M);
        chk("rst_empty",  32'(bus.empty), 32'd1);
        chk("rst_full",   32'(bus.full), 32'd0);
        chk("rst_count",  32'(bus.count), 32'd0);
        chk("rst_rdata",  32'(bus.rd_data), 32'h00);
        chk("rst_ferr",   32'(bus.frame_err), 32'd0);
        chk("rst_ovr",    32'(bus.overrun), 32'd0);
        chk("rst_perr",   32'(bus.parity_err), 32'd0);
        reset_of_clk10M = 1'b0;
        tick(20);

        // Single frame then pop
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        @(negedge clk_10M);
        chk("a5_rdata", 32'(bus.rd_data), 32'hA5);
        chk("a5_empty", 32'(bus.empty), 32'd0);
        chk("a5_count", 32'(bus.count), 32'd1);
        pop();
        chk("a5_empty_after", 32'(bus.empty), 32'd1);
        chk("a5_count_after", 32'(bus.count), 32'd0);

        // Fill to full, one extra frame overruns
        for (int i = 0; i < 17; i++) begin
            if (i < 16) exp_q.push_back(8'(i));
            send_frame(8'(i), 1'b1);
        end
        @(negedge clk_10M);
        chk("fill_full",  32'(bus.full), 32'd1);
        chk("fill_count", 32'(bus.count), 32'd16);
        chk("fill_ovr",   32'(bus.overrun), 32'd1);
        chk("fill_head",  32'(bus.rd_data), 32'h00);
        for (int i = 0; i < 16; i++) pop();
        chk("drain_empty", 32'(bus.empty), 32'd1);
        chk("drain_count", 32'(bus.count), 32'd0);
        chk("drain_full",  32'(bus.full), 32'd0);
        pulse_clr();
        chk("ovr_cleared", 32'(bus.overrun), 32'd0);

        // Bad stop bit
        send_frame(8'h3C, 1'b0);
        @(negedge clk_10M);
        chk("ferr_set",   32'(bus.frame_err), 32'd1);
        chk("ferr_count", 32'(bus.count), 32'd0);
        pulse_clr();
        chk("ferr_cleared", 32'(bus.frame_err), 32'd0);

        // Short low glitch
        bus.rxd = 1'b0;
        tick(20);
        bus.rxd = 1'b1;
        tick(200);
        @(negedge clk_10M);
        chk("glitch_count", 32'(bus.count), 32'd0);
        chk("glitch_ferr",  32'(bus.frame_err), 32'd0);
        chk("glitch_ovr",   32'(bus.overrun), 32'd0);
        chk("glitch_perr",  32'(bus.parity_err), 32'd0);

        // Reset during bit 4 of a frame, then a clean frame
        partial = 8'h33;
        bus.rxd = 1'b0;
        tick(BIT_CLKS);
        for (int i = 0; i < 4; i++) begin
            bus.rxd = partial[i];
            tick(BIT_CLKS);
        end
        bus.rxd = partial[4];
        tick(40);
        reset_of_clk10M = 1'b1;
        bus.rxd = 1'b1;
        tick(3);
        @(negedge clk_10M);
        chk("midrst_count", 32'(bus.count), 32'd0);
        chk("midrst_rdata", 32'(bus.rd_data), 32'h00);
        tick(1);
        reset_of_clk10M = 1'b0;
        tick(BIT_CLKS * 10);
        @(negedge clk_10M);
        chk("postrst_count", 32'(bus.count), 32'd0);
        tick(1);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        @(negedge clk_10M);
        chk("5a_count", 32'(bus.count), 32'd1);
        pop();
        chk("5a_empty_after", 32'(bus.empty), 32'd1);

`ifdef UART_RX_PARITY_EN
        tick(1);
        send_frame_par(8'h07, 1'b0);
        @(negedge clk_10M);
        chk("par_bad_err",   32'(bus.parity_err), 32'd1);
        chk("par_bad_count", 32'(bus.count), 32'd0);
        pulse_clr();
        chk("par_cleared", 32'(bus.parity_err), 32'd0);
        tick(1);
        exp_q.push_back(8'h07);
        send_frame_par(8'h07, 1'b1);
        @(negedge clk_10M);
        chk("par_ok_err",   32'(bus.parity_err), 32'd0);
        chk("par_ok_count", 32'(bus.count), 32'd1);
        pop();
`endif

        tick(4);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
